// File: rtl/stage3_fc_argmax.sv
// stage3_fc_argmax
//   Final classifier stage. Kernel dot-products arrive class-major, N_TERMS
//   beats per class. Each class score is the sum of its beats plus that class's
//   bias. A running max/argmax over N_CLASS scores produces one result per frame.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   i_clear         frame abort; drops the beat in the same cycle and cancels a pending compare
//   i_kernel_valid  beat qualifier (no backpressure)
//   i_kernel        signed kernel dot-product
//   i_bias          packed signed per-class biases, class c at [c*B_BW +: B_BW]
//   o_valid         one-cycle result pulse
//   o_class/o_score argmax class and its score; held until the next result
//   o_busy          frame in progress or compare pending
module stage3_fc_argmax #(
    parameter int IN_BW   = 20,
    parameter int N_TERMS = 16,
    parameter int N_CLASS = 26,
    parameter int B_BW    = 16,
    localparam int ACC_BW  = IN_BW + $clog2(N_TERMS),
    localparam int SC_BW   = ACC_BW + 1,
    localparam int CLS_BW  = $clog2(N_CLASS),
    localparam int TERM_BW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_clear,
    input  logic                      i_kernel_valid,
    input  logic signed [IN_BW-1:0]   i_kernel,
    input  logic [N_CLASS*B_BW-1:0]   i_bias,
    output logic                      o_valid,
    output logic [CLS_BW-1:0]         o_class,
    output logic signed [SC_BW-1:0]   o_score,
    output logic                      o_busy
);

    typedef enum logic {IDLE, ACC} state_t;

    state_t                    state_q,     state_d;
    logic [TERM_BW-1:0]        term_cnt_q,  term_cnt_d;
    logic [CLS_BW-1:0]         class_cnt_q, class_cnt_d;
    logic signed [ACC_BW-1:0]  acc_q,       acc_d;
    logic                      pending_q,   pending_d;
    logic [CLS_BW-1:0]         cmp_cls_q,   cmp_cls_d;
    logic                      cmp_last_q,  cmp_last_d;
    logic signed [SC_BW-1:0]   max_q,       max_d;
    logic [CLS_BW-1:0]         arg_q,       arg_d;
    logic                      o_valid_q,   o_valid_d;
    logic [CLS_BW-1:0]         o_class_q,   o_class_d;
    logic signed [SC_BW-1:0]   o_score_q,   o_score_d;

    logic                      last_term, last_class;
    logic signed [ACC_BW-1:0]  k_ext, acc_base;
    logic signed [B_BW-1:0]    bias_sel;
    logic signed [SC_BW-1:0]   score;

    always_comb begin
        last_term  = (term_cnt_q == TERM_BW'(N_TERMS - 1));
        last_class = (class_cnt_q == CLS_BW'(N_CLASS - 1));
        k_ext      = ACC_BW'(i_kernel);
        // First term of a class restarts the sum, so no separate acc clear is needed
        // and a back-to-back frame can overwrite acc while its old value is compared.
        acc_base   = (term_cnt_q == '0) ? '0 : acc_q;
        bias_sel   = i_bias[cmp_cls_q*B_BW +: B_BW];
        score      = SC_BW'(acc_q) + SC_BW'(bias_sel);

        state_d     = state_q;
        term_cnt_d  = term_cnt_q;
        class_cnt_d = class_cnt_q;
        acc_d       = acc_q;
        pending_d   = 1'b0;
        cmp_cls_d   = cmp_cls_q;
        cmp_last_d  = cmp_last_q;
        max_d       = max_q;
        arg_d       = arg_q;
        o_valid_d   = 1'b0;
        o_class_d   = o_class_q;
        o_score_d   = o_score_q;

        if (i_clear) begin
            state_d     = IDLE;
            term_cnt_d  = '0;
            class_cnt_d = '0;
        end else begin
            if (pending_q) begin
                // Class 0 loads unconditionally; later classes need a strict win.
                if (cmp_cls_q == '0 || score > max_q) begin
                    max_d = score;
                    arg_d = cmp_cls_q;
                end
                if (cmp_last_q) begin
                    o_valid_d = 1'b1;
                    o_class_d = arg_d;
                    o_score_d = max_d;
                end
            end
            if (i_kernel_valid) begin
                acc_d   = acc_base + k_ext;
                state_d = ACC;
                if (last_term) begin
                    term_cnt_d  = '0;
                    pending_d   = 1'b1;
                    cmp_cls_d   = class_cnt_q;
                    cmp_last_d  = last_class;
                    class_cnt_d = last_class ? '0 : class_cnt_q + 1'b1;
                    if (last_class) state_d = IDLE;
                end else begin
                    term_cnt_d = term_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            term_cnt_q  <= '0;
            class_cnt_q <= '0;
            acc_q       <= '0;
            pending_q   <= 1'b0;
            cmp_cls_q   <= '0;
            cmp_last_q  <= 1'b0;
            max_q       <= '0;
            arg_q       <= '0;
            o_valid_q   <= 1'b0;
            o_class_q   <= '0;
            o_score_q   <= '0;
        end else begin
            state_q     <= state_d;
            term_cnt_q  <= term_cnt_d;
            class_cnt_q <= class_cnt_d;
            acc_q       <= acc_d;
            pending_q   <= pending_d;
            cmp_cls_q   <= cmp_cls_d;
            cmp_last_q  <= cmp_last_d;
            max_q       <= max_d;
            arg_q       <= arg_d;
            o_valid_q   <= o_valid_d;
            o_class_q   <= o_class_d;
            o_score_q   <= o_score_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_class = o_class_q;
    assign o_score = o_score_q;
    assign o_busy  = (state_q == ACC) | pending_q;

endmodule

// File: tb/tb_stage3_fc_argmax.sv
module tb_stage3_fc_argmax;

    localparam int NT = 16;
    localparam int NC = 26;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 i_clear;
    logic                 i_kernel_valid;
    logic signed [19:0]   i_kernel;
    logic [NC*16-1:0]     i_bias;
    logic                 o_valid;
    logic [4:0]           o_class;
    logic signed [24:0]   o_score;
    logic                 o_busy;

    stage3_fc_argmax dut (
        .clk(clk), .reset(reset), .i_clear(i_clear),
        .i_kernel_valid(i_kernel_valid), .i_kernel(i_kernel), .i_bias(i_bias),
        .o_valid(o_valid), .o_class(o_class), .o_score(o_score), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef struct { int cls; int score; int cyc; } exp_t;
    exp_t exp_q[$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int pushed = 0;
    int pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every result pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!reset && o_valid) begin
            pulses++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse actual=1 required=0 (cyc %0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("o_class", int'(o_class), e.cls);
                chk("o_score", int'(o_score), e.score);
                chk("latency", cyc, e.cyc);
            end
        end
    end

    // Directed kernel patterns; expected winners are worked out by hand at each call.
    function automatic int kval(int mode, int c, int t);
        case (mode)
            0: return (c == 5) ? 1 : 0;
            1: return (c == 3 && t == 0) ? 10 : ((c == 7 && t < 10) ? 1 : 0);
            2: return -524288;
            3: return (c == 12) ? 3 : 0;
            4: return (c == 20) ? -1 : -2;
            5: return (c == 0) ? 7 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic drive(input logic v, input int k, input logic clr);
        @(negedge clk);
        i_kernel_valid = v;
        i_kernel       = 20'(k);
        i_clear        = clr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0);
    endtask

    task automatic send_frame(input int mode, input bit gaps, input bit push,
                              input int ecls, input int escore);
        for (int c = 0; c < NC; c++)
            for (int t = 0; t < NT; t++) begin
                if (gaps) idle($urandom_range(0, 2));
                drive(1'b1, kval(mode, c, t), 1'b0);
                if (push && c == NC-1 && t == NT-1) begin
                    exp_q.push_back('{ecls, escore, cyc + 2});
                    pushed++;
                end
            end
    endtask

    task automatic set_bias(input int c, input int v);
        i_bias[c*16 +: 16] = 16'(v);
    endtask

    initial begin
        reset = 1'b1; i_clear = 1'b0; i_kernel_valid = 1'b0; i_kernel = '0; i_bias = '0;

        // Reset with beats driven
        for (int i = 0; i < 3; i++) drive(1'b1, 3, 1'b0);
        @(negedge clk);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_class", int'(o_class), 0);
        chk("rst_score", int'(o_score), 0);
        chk("rst_busy",  int'(o_busy), 0);
        i_kernel_valid = 1'b0;
        reset = 1'b0;
        idle(2);

        // Single class wins; busy covers the pending compare cycle only
        send_frame(0, 0, 1, 5, 16);
        idle(1);
        chk("busy_pending", int'(o_busy), 1);
        idle(1);
        chk("busy_done", int'(o_busy), 0);
        idle(3);

        // Tie keeps the lower index
        send_frame(1, 0, 1, 3, 10);
        idle(4);

        // Most-negative beats, bias on the last class
        set_bias(25, 5);
        send_frame(2, 0, 1, 25, -8388603);
        idle(4);
        i_bias = '0;

        // Bias indexing: all sums zero, biases decide
        set_bias(0, -100); set_bias(2, -4); set_bias(17, 9);
        send_frame(6, 0, 1, 17, 9);
        idle(4);
        i_bias = '0;

        // Back-to-back frames, then a frame with random gaps
        send_frame(0, 0, 1, 5, 16);
        send_frame(3, 0, 1, 12, 48);
        send_frame(4, 1, 1, 20, -16);
        idle(4);

        // Clear during class 10 with a beat in the same cycle
        for (int c = 0; c <= 10; c++)
            for (int t = 0; t < NT; t++)
                if (c < 10 || t < 4) drive(1'b1, kval(3, c, t), 1'b0);
        drive(1'b1, 5, 1'b1);
        idle(1);
        chk("busy_after_clear", int'(o_busy), 0);
        send_frame(5, 0, 1, 0, 112);
        idle(4);

        // Clear in the pending cycle cancels the result
        send_frame(0, 0, 0, 0, 0);
        drive(1'b0, 0, 1'b1);
        idle(5);
        chk("hold_class", int'(o_class), 0);
        chk("hold_score", int'(o_score), 112);
        chk("idle_busy", int'(o_busy), 0);

        chk("queue_drain", exp_q.size(), 0);
        chk("pulse_count", pulses, pushed);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
